// File: rtl/poly_tomont_pkg.sv
// -----------------------------------------------------------------------------
// poly_tomont_pkg
// Shared Kyber arithmetic definitions for the polynomial Montgomery-entry
// block and its reduction pipeline.
//   KYBER_N       coefficients per polynomial
//   KYBER_Q       Kyber modulus
//   KYBER_QINV    q^-1 mod 2^16 as a signed 16-bit value, so that
//                 (p*QINV mod 2^16)*q has the same low 16 bits as p
//   KYBER_R2MODQ  2^32 mod q; multiplying by it before a Montgomery
//                 reduction lands the result at a*2^16 mod q
//   coeff_t       signed 16-bit coefficient
//   prod_t        signed 32-bit product
//   state_t       polynomial sequencing states
// -----------------------------------------------------------------------------
package poly_tomont_pkg;

    localparam int KYBER_N      = 256;
    localparam int KYBER_Q      = 3329;
    localparam int KYBER_QINV   = -3327;
    localparam int KYBER_R2MODQ = 1353;

    typedef logic signed [15:0] coeff_t;
    typedef logic signed [31:0] prod_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/poly_tomont_if.sv
// -----------------------------------------------------------------------------
// poly_tomont_if
// Coefficient stream bundle for poly_tomont: an input valid/ready channel and
// an output valid/ready channel with an end-of-polynomial marker.
//   in_valid / in_ready / in_data        coefficient into the block
//   out_valid / out_ready / out_data     Montgomery-form coefficient out
//   out_last                             marks coefficient index N-1
// The master modport is the environment (feeds inputs, accepts outputs);
// the slave modport is the converter itself.
// -----------------------------------------------------------------------------
interface poly_tomont_if;
    import poly_tomont_pkg::*;

    logic   in_valid;
    logic   in_ready;
    coeff_t in_data;

    logic   out_valid;
    logic   out_ready;
    coeff_t out_data;
    logic   out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/poly_tomont_mont_reduce_pipe.sv
// -----------------------------------------------------------------------------
// poly_tomont_mont_reduce_pipe
// Two registered stages of signed Montgomery reduction: for a 32-bit product
// p with |p| < q*2^15 it produces p*2^-16 mod q in [-(q-1), q-1].
// Written to be reusable by the basemul datapath as well.
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   en         advance both stages; when low every register holds
//   in_valid   p_in carries a product this cycle
//   p_in       signed 32-bit product to reduce
//   out_valid  out_data carries a reduced coefficient
//   out_data   signed reduced coefficient
// -----------------------------------------------------------------------------
module poly_tomont_mont_reduce_pipe
    import poly_tomont_pkg::*;
#(
    parameter int Q    = KYBER_Q,
    parameter int QINV = KYBER_QINV
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   in_valid,
    input  prod_t  p_in,
    output logic   out_valid,
    output coeff_t out_data
);

    localparam logic [15:0] QINV_LO = 16'(QINV);
    localparam prod_t       Q_P     = prod_t'(Q);

    logic [15:0] u_lo;
    coeff_t      u;
    coeff_t      v_hi;

    logic        s2_valid;
    coeff_t      s2_p_hi;
    coeff_t      s2_v_hi;

    // u only needs the low 16 bits of p*QINV, so a 16x16 truncated multiply
    // is enough. v = u*q agrees with p in its low 16 bits, which means
    // (p - v) >>> 16 equals p_hi - v_hi exactly: only the upper halves need
    // to be carried into the last stage.
    always_comb begin
        u_lo = p_in[15:0] * QINV_LO;
        u    = coeff_t'(u_lo);
        v_hi = coeff_t'((prod_t'(u) * Q_P) >>> 16);
    end

    // Data registers load only alongside a valid beat so a stalled or idle
    // output keeps presenting the last real coefficient.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_p_hi   <= '0;
            s2_v_hi   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            s2_valid  <= in_valid;
            out_valid <= s2_valid;
            if (in_valid) begin
                s2_p_hi <= p_in[31:16];
                s2_v_hi <= v_hi;
            end
            if (s2_valid) begin
                out_data <= s2_p_hi - s2_v_hi;
            end
        end
    end

endmodule

// File: rtl/poly_tomont.sv
// -----------------------------------------------------------------------------
// poly_tomont
// Streams one Kyber polynomial of N coefficients into the Montgomery domain:
// out = a*2^16 mod q, computed as the Montgomery reduction of a*R2MODQ.
// Three-stage pipeline (multiply, then two reduction stages) with a global
// stall driven by the output side.
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse arming a new polynomial (only honoured in IDLE)
//   busy       high while a polynomial is being accepted or drained
//   done       one-cycle pulse after the final output handshake
//   bus        coefficient stream (slave side), see poly_tomont_if
// -----------------------------------------------------------------------------
module poly_tomont
    import poly_tomont_pkg::*;
#(
    parameter int N      = KYBER_N,
    parameter int Q      = KYBER_Q,
    parameter int QINV   = KYBER_QINV,
    parameter int R2MODQ = KYBER_R2MODQ
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    poly_tomont_if.slave bus
);

    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam prod_t          R2_P     = prod_t'(R2MODQ);

    state_t        state;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;

    logic          advance;
    logic          in_ready;
    logic          in_hs;
    logic          out_hs;

    logic          s1_valid;
    prod_t         s1_p;

    logic          pipe_valid;
    coeff_t        pipe_data;

    // The whole pipeline moves together: it advances whenever the output
    // register is empty or being taken this cycle.
    assign advance  = bus.out_ready || !pipe_valid;
    assign in_ready = (state == ST_RUN) && advance;
    assign in_hs    = bus.in_valid && in_ready;
    assign out_hs   = pipe_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = pipe_valid;
    assign bus.out_data  = pipe_data;
    assign bus.out_last  = pipe_valid && (out_cnt == LAST_IDX);

    // S1: scale by 2^32 mod q; |a*R2MODQ| < 2^26 so 32 bits never overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
        end else if (advance) begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_p <= prod_t'(bus.in_data) * R2_P;
            end
        end
    end

    // S2/S3: Montgomery reduction of the scaled product.
    poly_tomont_mont_reduce_pipe #(
        .Q    (Q),
        .QINV (QINV)
    ) u_reduce (
        .clk       (clk),
        .reset     (reset),
        .en        (advance),
        .in_valid  (s1_valid),
        .p_in      (s1_p),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // Sequencing: RUN accepts N inputs, DRAIN waits for N outputs.
    // A start seen while done is still high belongs to the cycle the
    // previous polynomial is finishing in, so it is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    if (start && !done) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_hs) begin
                        in_cnt <= in_cnt + CNT_ONE;
                        if (in_cnt == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end
                    end
                    if (out_hs) begin
                        out_cnt <= out_cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs) begin
                        out_cnt <= out_cnt + CNT_ONE;
                        if (out_cnt == LAST_IDX) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_tomont.sv
// -----------------------------------------------------------------------------
// tb_poly_tomont
// Directed bench for poly_tomont: each polynomial starts with a fixed set of
// coefficients whose Montgomery forms were worked out by hand, followed by a
// ramp or random values that are checked for range and congruence to
// a*2^16 mod q (2^16 mod 3329 = 2285).
// -----------------------------------------------------------------------------
module tb_poly_tomont;
    import poly_tomont_pkg::*;

    localparam int N = 256;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    poly_tomont_if bus ();

    poly_tomont #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    coeff_t vec [N];
    coeff_t dir_tab   [7] = '{16'sd0, 16'sd1, -16'sd1, 16'sd2, 16'sd32767, -16'sd32768, 16'sd3};
    int     exact_tab [7] = '{0, -1044, 1044, 1241, 56, 988, 197};

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modq(input int x);
        int r;
        r = x % 3329;
        if (r < 0) r += 3329;
        return r;
    endfunction

    task automatic checkCoeff(input int idx, input coeff_t obs);
        if (idx < 7) checkOutput($sformatf("exact[%0d]", idx), obs, exact_tab[idx]);
        checkOutput($sformatf("cong[%0d]", idx), modq(int'(obs)), modq(int'(vec[idx]) * 2285));
        checkOutput($sformatf("range[%0d]", idx), (obs >= -16'sd3328 && obs <= 16'sd3328), 1);
    endtask

    task automatic fillVec(input bit randomRest);
        for (int i = 0; i < N; i++) begin
            if (i < 7)           vec[i] = dir_tab[i];
            else if (randomRest) vec[i] = coeff_t'($urandom);
            else                 vec[i] = coeff_t'(i);
        end
    endtask

    // All driving tasks start and end at 1 time unit after a rising edge.
    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input coeff_t d);
        int waitCnt;
        waitCnt = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.in_ready) checkOutput("in_timeout", waitCnt, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Full-rate polynomial with out_ready held high; checks latency,
    // in_ready/out_last timing, done pulse, and optionally a start pulse
    // on the done cycle.
    task automatic runLockstep(input bit startOnDone);
        fillVec(1'b0);
        bus.out_ready = 1'b1;
        pulseStart();
        for (int c = 0; c < N + 3; c++) begin
            if (c < N) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vec[c];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput($sformatf("ls_in_ready[%0d]", c), bus.in_ready, (c < N));
            checkOutput($sformatf("ls_out_valid[%0d]", c), bus.out_valid, (c >= 3));
            checkOutput($sformatf("ls_busy[%0d]", c), busy, 1);
            if (c >= 3) begin
                checkCoeff(c - 3, bus.out_data);
                checkOutput($sformatf("ls_last[%0d]", c), bus.out_last, (c == N + 2));
            end
            @(posedge clk); #1;
        end
        start = startOnDone;
        @(negedge clk);
        checkOutput("ls_done_pulse", done, 1);
        checkOutput("ls_busy_after", busy, 0);
        checkOutput("ls_valid_after", bus.out_valid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("ls_done_low", done, 0);
        checkOutput("ls_busy_idle", busy, 0);
        checkOutput("ls_in_ready_idle", bus.in_ready, 0);
        @(posedge clk); #1;
    endtask

    // Random input gaps and 50% output backpressure, plus a start pulse
    // while running.
    task automatic runRandom();
        fillVec(1'b1);
        pulseStart();
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    if (i == 50) start = 1'b1;
                    applyStimulus(vec[i]);
                    start = 1'b0;
                end
            end
            begin
                int     k;
                int     cyc;
                bit     held;
                coeff_t heldData;
                logic   heldLast;
                k = 0;
                cyc = 0;
                held = 1'b0;
                heldData = '0;
                heldLast = 1'b0;
                while (k < N && cyc < 20000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cyc++;
                    if (held) begin
                        checkOutput("hold_valid", bus.out_valid, 1);
                        checkOutput("hold_data", bus.out_data, heldData);
                        checkOutput("hold_last", bus.out_last, heldLast);
                    end
                    held = 1'b0;
                    if (bus.out_valid) begin
                        if (bus.out_ready) begin
                            checkCoeff(k, bus.out_data);
                            checkOutput($sformatf("rnd_last[%0d]", k), bus.out_last, (k == N - 1));
                            k++;
                        end else begin
                            held     = 1'b1;
                            heldData = bus.out_data;
                            heldLast = bus.out_last;
                        end
                    end
                    @(posedge clk); #1;
                end
                if (k < N) checkOutput("out_timeout", k, N);
                bus.out_ready = 1'b1;
            end
        join
        @(negedge clk);
        checkOutput("rnd_done", done, 1);
        checkOutput("rnd_busy", busy, 0);
        checkOutput("rnd_no_extra", bus.out_valid, 0);
        @(posedge clk); #1;
    endtask

    // Asynchronous reset in the middle of a polynomial, then a clean one.
    task automatic runResetMid();
        fillVec(1'b0);
        bus.out_ready = 1'b1;
        pulseStart();
        for (int i = 0; i < 100; i++) applyStimulus(vec[i]);
        checkOutput("pre_reset_valid", bus.out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", bus.out_valid, 0);
        checkOutput("mid_rst_data", bus.out_data, 0);
        checkOutput("mid_rst_last", bus.out_last, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        runLockstep(1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_out_last", bus.out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        $display("[TB] full-rate polynomial, start pulsed on done");
        runLockstep(1'b1);
        $display("[TB] backpressure polynomials");
        runRandom();
        runRandom();
        $display("[TB] reset mid-polynomial");
        runResetMid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
